// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: free-running 16x tick, 2-flop rx synchroniser, start/data[/parity]/stop FSM, one-entry valid/ready holding register.
// rx_valid/rx_done rise 1 clk after the stop-sample tick; a full, unread holding register drops the new byte and sets overrun. Optional parity: UART_RX_PARITY_EN.
module uart_rx_ctrl #(
  parameter int DBITS      = 8,
  parameter int CLK_DIV    = 27,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             rx_ready,
  output logic [DBITS-1:0] rx_dout,
  output logic             rx_valid,
  output logic             rx_done,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int              CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [3:0]      DLAST     = 4'(DBITS - 1);

  if (DBITS < 5 || DBITS > 8 || CLK_DIV < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_chk
    $error("uart_rx_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state;
  logic [CW-1:0]    tick_cnt;
  logic             tick;
  logic             rx_meta;
  logic             rx_s;
  logic [3:0]       os_cnt;
  logic [3:0]       data_cnt;
  logic [DBITS-1:0] shift;
  logic             stop_sample;
  logic             frame_ok;
  logic             hs;
  logic             par_bad;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // Sync flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      os_cnt   <= '0;
      data_cnt <= '0;
      shift    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state  <= S_START;
            os_cnt <= '0;
          end
        end
        S_START: begin
          if (os_cnt == 4'd7) begin
            if (!rx_s) begin
              state    <= S_DATA;
              os_cnt   <= '0;
              data_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            os_cnt <= os_cnt + 4'd1;
          end
        end
        S_DATA: begin
          if (os_cnt == 4'd15) begin
            shift  <= {rx_s, shift[DBITS-1:1]};
            os_cnt <= '0;
            if (data_cnt == DLAST) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end else begin
              data_cnt <= data_cnt + 4'd1;
            end
          end else begin
            os_cnt <= os_cnt + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (os_cnt == 4'd15) begin
            par_bit <= rx_s;
            os_cnt  <= '0;
            state   <= S_STOP;
          end else begin
            os_cnt <= os_cnt + 4'd1;
          end
        end
`endif
        S_STOP: begin
          if (os_cnt == 4'd15) begin
            state  <= S_IDLE;
            os_cnt <= '0;
          end else begin
            os_cnt <= os_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stop_sample = tick && (state == S_STOP) && (os_cnt == 4'd15);
  assign frame_ok    = stop_sample && rx_s;
  assign hs          = rx_valid && rx_ready;

`ifdef UART_RX_PARITY_EN
  assign par_bad = (^shift) ^ PARITY_ODD[0] ^ par_bit;
`else
  assign par_bad = 1'b0;
`endif

  // A frame landing in the same cycle the consumer drains the register is still accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_dout    <= '0;
      rx_valid   <= 1'b0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (stop_sample && !rx_s) frame_err <= 1'b1;
      if (frame_ok && (!rx_valid || rx_ready)) begin
        rx_dout    <= shift;
        rx_valid   <= 1'b1;
        rx_done    <= 1'b1;
        parity_err <= par_bad;
      end else if (hs) begin
        rx_valid <= 1'b0;
      end
      if (frame_ok && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (hs)                           overrun <= 1'b0;
    end
  end

endmodule
